// File: rtl/radix_4_div_16x8.sv
// Radix-4 restoring divider, 16-bit dividend / 8-bit divisor; RADIX4_DIV_SIGNED_EN selects two's-complement operands.
// 8-cycle latency (1 for Y=0), start/done handshake; start is ignored while busy, so issue rate is one per 9 cycles.
module radix_4_div_16x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] X,
    input  logic [7:0]  Y,
    output logic        busy,
    output logic        done,
    output logic [15:0] Q,
    output logic [7:0]  R,
    output logic        dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  d_q, d_d;
    logic [9:0]  pr_q, pr_d;
    logic [15:0] quo_q, quo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] q_out_q, q_out_d;
    logic [7:0]  r_out_q, r_out_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;

    logic [15:0] abs_x;
    logic [7:0]  abs_y;
    logic [15:0] q_fin;
    logic [7:0]  r_fin;

    logic [9:0]  t;
    logic [9:0]  d3;
    logic [10:0] diff1, diff2, diff3;
    logic [1:0]  digit;
    logic [9:0]  pr_step;

`ifdef RADIX4_DIV_SIGNED_EN
    logic sx_q, sx_d;
    logic sy_q, sy_d;

    always_comb begin
        abs_x = X[15] ? (~X + 16'd1) : X;
        abs_y = Y[7]  ? (~Y + 8'd1)  : Y;
        q_fin = (sx_q ^ sy_q) ? (~quo_d + 16'd1) : quo_d;
        r_fin = sx_q ? (~pr_d[7:0] + 8'd1) : pr_d[7:0];
    end
`else
    always_comb begin
        abs_x = X;
        abs_y = Y;
        q_fin = quo_d;
        r_fin = pr_d[7:0];
    end
`endif

    // One radix-4 step: PR < D keeps every trial difference inside 11 bits.
    always_comb begin
        t     = (pr_q << 2) | {8'd0, dvd_q[15:14]};
        d3    = {1'b0, d_q, 1'b0} + {2'b00, d_q};
        diff1 = {1'b0, t} - {3'b000, d_q};
        diff2 = {1'b0, t} - {2'b00, d_q, 1'b0};
        diff3 = {1'b0, t} - {1'b0, d3};
        if (!diff3[10]) begin
            digit   = 2'd3;
            pr_step = diff3[9:0];
        end else if (!diff2[10]) begin
            digit   = 2'd2;
            pr_step = diff2[9:0];
        end else if (!diff1[10]) begin
            digit   = 2'd1;
            pr_step = diff1[9:0];
        end else begin
            digit   = 2'd0;
            pr_step = t;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        d_d     = d_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
`ifdef RADIX4_DIV_SIGNED_EN
        sx_d    = sx_q;
        sy_d    = sy_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pr_d  = 10'd0;
                    cnt_d = 3'd0;
                    quo_d = 16'd0;
                    if (Y == 8'd0) begin
                        // Raw X is kept so the zero path can report its low byte.
                        state_d = S_ZERO;
                        dvd_d   = X;
                    end else begin
                        state_d = S_RUN;
                        dvd_d   = abs_x;
                        d_d     = abs_y;
`ifdef RADIX4_DIV_SIGNED_EN
                        sx_d    = X[15];
                        sy_d    = Y[7];
`endif
                    end
                end
            end
            S_RUN: begin
                dvd_d = {dvd_q[13:0], 2'b00};
                pr_d  = pr_step;
                quo_d = {quo_q[13:0], digit};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    q_out_d = q_fin;
                    r_out_d = r_fin;
                    dz_d    = 1'b0;
                end
            end
            S_ZERO: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                q_out_d = 16'hFFFF;
                r_out_d = dvd_q[7:0];
                dz_d    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 16'd0;
            d_q     <= 8'd0;
            pr_q    <= 10'd0;
            quo_q   <= 16'd0;
            cnt_q   <= 3'd0;
            q_out_q <= 16'd0;
            r_out_q <= 8'd0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef RADIX4_DIV_SIGNED_EN
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            d_q     <= d_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
`ifdef RADIX4_DIV_SIGNED_EN
            sx_q    <= sx_d;
            sy_q    <= sy_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign Q    = q_out_q;
    assign R    = r_out_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_radix_4_div_16x8.sv
// Scoreboarded bench for radix_4_div_16x8: stimulus pushes expected results, a negedge monitor checks each done.
module tb_radix_4_div_16x8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] X;
    logic [7:0]  Y;
    logic        busy;
    logic        done;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        dz;

    radix_4_div_16x8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("Q", {16'd0, Q}, {16'd0, mon_e.q});
                chk("R", {24'd0, R}, {24'd0, mon_e.r});
                chk("dz", {31'd0, dz}, {31'd0, mon_e.dz});
                chk("done_cycle", cyc, mon_e.cyc);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called at a negedge; start is held for exactly one rising edge.
    task automatic issue(input logic [15:0] x, input logic [7:0] y, input logic [15:0] eq,
                         input logic [7:0] er, input logic edz, input bit expect_it);
        exp_t e;
        X     = x;
        Y     = y;
        start = 1'b1;
        if (expect_it) begin
            e.q   = eq;
            e.r   = er;
            e.dz  = edz;
            e.cyc = cyc + 1 + ((y == 8'd0) ? 1 : 8);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_one(input logic [15:0] x, input logic [7:0] y, input logic [15:0] eq,
                           input logic [7:0] er, input logic edz);
        issue(x, y, eq, er, edz, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    logic [15:0] rx;
    logic [7:0]  ry;
    logic [31:0] tq, tr;
    int          xs, ys;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        X     = 16'd0;
        Y     = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_Q", {16'd0, Q}, 32'd0);
        chk("rst_R", {24'd0, R}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic latency and busy window.
        issue(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b1);
        chk("busy_run", {31'd0, busy}, 32'd1);
        wait_done();
        @(negedge clk);

        // Back-to-back: second start is driven during the first done cycle.
`ifdef RADIX4_DIV_SIGNED_EN
        issue(16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0, 1'b1);
        wait_done();
        issue(16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
`else
        issue(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 1'b1);
        wait_done();
        issue(16'd255, 8'd1, 16'd255, 8'd0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
`endif

        // Divide by zero, then a valid division clears dz.
        issue(16'h04D2, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1'b1);
        chk("busy_zero", {31'd0, busy}, 32'd1);
        wait_done();
        @(negedge clk);
        run_one(16'd50, 8'd5, 16'd10, 8'd0, 1'b0);

        // A start while busy is ignored.
        issue(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 1'b1);
        @(negedge clk);
        issue(16'd5, 8'd5, 16'd0, 8'd0, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);

        // Reset mid-run aborts without a done pulse.
        issue(16'd1234, 8'd10, 16'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_Q", {16'd0, Q}, 32'd0);
        chk("abort_R", {24'd0, R}, 32'd0);
        repeat (12) @(negedge clk);
        run_one(16'd9, 8'd4, 16'd2, 8'd1, 1'b0);

        // Random sweep against integer division.
        for (int i = 0; i < 24; i++) begin
            rx = 16'($urandom);
            ry = 8'($urandom_range(1, 255));
`ifdef RADIX4_DIV_SIGNED_EN
            xs = $signed(rx);
            ys = $signed(ry);
            tq = xs / ys;
            tr = xs % ys;
`else
            tq = {16'd0, rx} / {24'd0, ry};
            tr = {16'd0, rx} % {24'd0, ry};
`endif
            run_one(rx, ry, tq[15:0], tr[7:0], 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
